// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter encodings and saturating update for the branch predictor
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'd1;
    end
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_btb_array.sv
// rtl/bp_btb_array.sv - direct-mapped BTB storage: one combinational read port, one training write port
// The write port does its own hit check so the caller only supplies the resolved branch.
module bp_btb_array
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int IDXW    = $clog2(ENTRIES),
  parameter int TAGW    = XLEN - IDXW - 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IDXW-1:0] rd_idx,
  input  logic [TAGW-1:0] rd_tag,
  output logic            rd_hit,
  output logic [1:0]      rd_ctr,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [TAGW-1:0] wr_tag,
  input  logic            wr_taken,
  input  logic [XLEN-1:0] wr_target,
  output logic            wr_hit
);

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  ctr_t            ctr_q    [ENTRIES];
  logic            valid_d  [ENTRIES];
  logic [TAGW-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0] target_d [ENTRIES];
  ctr_t            ctr_d    [ENTRIES];

  // Reads come straight from the registered arrays: a same-cycle write is not bypassed.
  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_ctr    = ctr_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (wr_en) begin
      if (wr_hit) begin
        ctr_d[wr_idx] = sat_update(ctr_q[wr_idx], wr_taken);
        if (wr_taken) begin
          target_d[wr_idx] = wr_target;
        end
      end else if (wr_taken) begin
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = wr_target;
        ctr_d[wr_idx]    = CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch-side BTB predictor with mispredict/redirect generation
// Optional performance counters are enabled with BRANCH_PREDICTOR_PERF_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int IDXW    = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_PREDICTOR_PERF_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts,
  output logic [31:0]     perf_btb_hits
`endif
);

  localparam int TAGW = XLEN - IDXW - 2;

  logic            rd_hit;
  logic [1:0]      rd_ctr;
  logic [XLEN-1:0] rd_target;
  logic            upd_hit;
  logic            miss_dir;
  logic            miss_tgt;
  logic            unused_bits;

  bp_btb_array #(
    .XLEN    (XLEN),
    .ENTRIES (ENTRIES),
    .IDXW    (IDXW),
    .TAGW    (TAGW)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (if_pc[IDXW+1:2]),
    .rd_tag    (if_pc[XLEN-1:IDXW+2]),
    .rd_hit    (rd_hit),
    .rd_ctr    (rd_ctr),
    .rd_target (rd_target),
    .wr_en     (upd_valid),
    .wr_idx    (upd_pc[IDXW+1:2]),
    .wr_tag    (upd_pc[XLEN-1:IDXW+2]),
    .wr_taken  (upd_taken),
    .wr_target (upd_target),
    .wr_hit    (upd_hit)
  );

  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_hit};

  // The mispredict path is purely combinational, so it must be masked while reset is held.
  always_comb begin
    pred_taken  = !reset && rd_hit && rd_ctr[1];
    pred_target = pred_taken ? rd_target : '0;
    miss_dir    = upd_taken != upd_pred_taken;
    miss_tgt    = upd_taken && upd_pred_taken && (upd_target != upd_pred_target);
    mispredict  = !reset && upd_valid && (miss_dir || miss_tgt);
    redirect_pc = '0;
    if (mispredict) begin
      redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
    end
  end

`ifdef BRANCH_PREDICTOR_PERF_EN
  logic [31:0] branches_q, branches_d;
  logic [31:0] mispredicts_q, mispredicts_d;
  logic [31:0] hits_q, hits_d;

  always_comb begin
    branches_d    = branches_q + {31'd0, upd_valid};
    mispredicts_d = mispredicts_q + {31'd0, mispredict};
    hits_d        = hits_q + {31'd0, upd_valid && upd_hit};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
      hits_q        <= '0;
    end else begin
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
      hits_q        <= hits_d;
    end
  end

  assign perf_branches    = branches_q;
  assign perf_mispredicts = mispredicts_q;
  assign perf_btb_hits    = hits_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BRANCH_PREDICTOR_PERF_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
  logic [31:0] perf_btb_hits;
`endif

  int total = 0;
  int bad   = 0;

  branch_predictor dut (
    .clk             (clk),
    .reset           (reset),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
`ifdef BRANCH_PREDICTOR_PERF_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts),
    .perf_btb_hits    (perf_btb_hits)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic t,
                         input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
    upd_valid = v; upd_pc = pc; upd_taken = t;
    upd_target = tg; upd_pred_taken = pt; upd_pred_target = ptg;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_pc = 32'h100;
    set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    tick();
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken got=%0b want=0", pred_taken); end
    total++; if (pred_target !== 32'h0) begin bad++; $display("FAIL reset_pred_target got=%h want=0", pred_target); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL reset_mispredict got=%0b want=0", mispredict); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redirect got=%h want=0", redirect_pc); end
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_miss_not_taken();
    if_pc = 32'h100;
    set_upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL cold_pred_taken got=%0b want=0", pred_taken); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL nt_mispredict got=%0b want=0", mispredict); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL nt_redirect got=%h want=0", redirect_pc); end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL nt_no_alloc got=%0b want=0", pred_taken); end
  endtask

  task automatic test_allocate();
    tick();
    set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL alloc_mispredict got=%0b want=1", mispredict); end
    total++; if (redirect_pc !== 32'h80) begin bad++; $display("FAIL alloc_redirect got=%h want=00000080", redirect_pc); end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    if_pc = 32'h100;
    #1;
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alloc_pred_taken got=%0b want=1", pred_taken); end
    total++; if (pred_target !== 32'h80) begin bad++; $display("FAIL alloc_pred_target got=%h want=00000080", pred_target); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      tick();
      set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      #1;
      total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL sat_taken_mispredict[%0d] got=%0b want=0", i, mispredict); end
    end
    tick();
    set_upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    #1;
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL sat_nt_mispredict got=%0b want=1", mispredict); end
    total++; if (redirect_pc !== 32'h104) begin bad++; $display("FAIL sat_nt_redirect got=%h want=00000104", redirect_pc); end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_one_nt_pred got=%0b want=1", pred_taken); end
    tick();
    set_upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL sat_two_nt_pred got=%0b want=0", pred_taken); end
    total++; if (pred_target !== 32'h0) begin bad++; $display("FAIL sat_two_nt_target got=%h want=0", pred_target); end
    tick();
    set_upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    #1;
    total++; if (redirect_pc !== 32'h104) begin bad++; $display("FAIL sat_third_nt_redirect got=%h want=00000104", redirect_pc); end
  endtask

  task automatic test_target_change();
    tick();
    set_upd(1'b1, 32'h100, 1'b1, 32'hC0, 1'b1, 32'h80);
    #1;
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL tgt_mispredict got=%0b want=1", mispredict); end
    total++; if (redirect_pc !== 32'hC0) begin bad++; $display("FAIL tgt_redirect got=%h want=000000c0", redirect_pc); end
    tick();
    set_upd(1'b1, 32'h100, 1'b1, 32'hC0, 1'b1, 32'hC0);
    #1;
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL tgt_match_mispredict got=%0b want=0", mispredict); end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    if_pc = 32'h100;
    #1;
    total++; if (pred_target !== 32'hC0) begin bad++; $display("FAIL tgt_lookup got=%h want=000000c0", pred_target); end
  endtask

  task automatic test_alias();
    tick();
    if_pc = 32'h140;
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_pre_miss got=%0b want=0", pred_taken); end
    set_upd(1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h0);
    if_pc = 32'h100;
    #1;
    total++; if (pred_target !== 32'hC0) begin bad++; $display("FAIL alias_old_entry got=%h want=000000c0", pred_target); end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_evicted got=%0b want=0", pred_taken); end
    if_pc = 32'h140;
    #1;
    total++; if (pred_target !== 32'h200) begin bad++; $display("FAIL alias_new_hit got=%h want=00000200", pred_target); end
    tick();
    set_upd(1'b1, 32'h140, 1'b1, 32'h300, 1'b1, 32'h200);
    #1;
    total++; if (redirect_pc !== 32'h300) begin bad++; $display("FAIL bypass_redirect got=%h want=00000300", redirect_pc); end
    total++; if (pred_target !== 32'h200) begin bad++; $display("FAIL bypass_old_value got=%h want=00000200", pred_target); end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    total++; if (pred_target !== 32'h300) begin bad++; $display("FAIL bypass_new_value got=%h want=00000300", pred_target); end
  endtask

  task automatic test_boundary();
    tick();
    set_upd(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
    #1;
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL wrap_redirect got=%h want=00000000", redirect_pc); end
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL wrap_mispredict got=%0b want=1", mispredict); end
    tick();
    set_upd(1'b0, 32'h184, 1'b1, 32'h500, 1'b0, 32'h0);
    #1;
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL idle_mispredict got=%0b want=0", mispredict); end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    if_pc = 32'h184;
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL idle_no_alloc got=%0b want=0", pred_taken); end
  endtask

  task automatic test_reset_mid_update();
    tick();
    if_pc = 32'h140;
    set_upd(1'b1, 32'h144, 1'b1, 32'h600, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL mid_reset_pred got=%0b want=0", pred_taken); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL mid_reset_mispredict got=%0b want=0", mispredict); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL mid_reset_redirect got=%h want=0", redirect_pc); end
`ifdef BRANCH_PREDICTOR_PERF_EN
    total++; if (perf_branches !== 32'h0) begin bad++; $display("FAIL perf_branches got=%0d want=0", perf_branches); end
    total++; if (perf_mispredicts !== 32'h0) begin bad++; $display("FAIL perf_mispredicts got=%0d want=0", perf_mispredicts); end
    total++; if (perf_btb_hits !== 32'h0) begin bad++; $display("FAIL perf_btb_hits got=%0d want=0", perf_btb_hits); end
`endif
    tick();
    reset = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL post_reset_cleared got=%0b want=0", pred_taken); end
    if_pc = 32'h144;
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL post_reset_discard got=%0b want=0", pred_taken); end
  endtask

  initial begin
    if_pc = 32'h0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_miss_not_taken();
    test_allocate();
    test_saturation();
    test_target_change();
    test_alias();
    test_boundary();
    test_reset_mid_update();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor: the initiator-side counterpart of the execute-stage branch resolver.
- IF stage asks it whether the current PC is a taken branch and where it goes.
- EX stage sends back the resolved outcome (taken, target). The block trains its tables and flags mispredicts for pipeline flush and redirect.
- Direct-mapped BTB with tag, target and a 2-bit saturating counter per entry.

Parameters:
- XLEN, 32, address/PC width.
- ENTRIES, 16, number of BTB/BHT entries; power of two, at least 2.
- IDXW, $clog2(ENTRIES), index width (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_pc  in  XLEN  PC of the instruction being fetched.
- pred_taken  out  1  predict taken for if_pc.
- pred_target  out  XLEN  predicted target; valid only when pred_taken=1, otherwise 0.
- upd_valid  in  1  EX holds a resolved conditional branch this cycle.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  resolved outcome (the branch resolver's taken).
- upd_target  in  XLEN  computed branch target.
- upd_pred_taken  in  1  prediction that travelled down the pipe with this branch.
- upd_pred_target  in  XLEN  predicted target that travelled with it.
- mispredict  out  1  flush request for IF/ID.
- redirect_pc  out  XLEN  correct next PC when mispredict=1, otherwise 0.

Behaviour:
- Address split: index = pc[IDXW+1:2]; tag = pc[XLEN-1:IDXW+2]; pc[1:0] ignored.
- Per-entry state: valid (1), tag, target (XLEN), ctr (2).
- Reset (async, immediate): all valid=0, all ctr=2'b01 (weakly not-taken). Tags and targets are cleared to 0.
- Outputs while reset is asserted: pred_taken=0, pred_target=0, mispredict=0, redirect_pc=0.
- Lookup is combinational, same cycle:
  - hit = valid[idx] & (tag[idx]==if_tag).
  - pred_taken = hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : 0.
- Mispredict is combinational from upd_*, zero latency. mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target))).
- Redirect: redirect_pc = upd_taken ? upd_target : upd_pc+4 (mod 2^XLEN), gated to 0 when mispredict=0.
- Training, on the rising edge with upd_valid=1:
  - Hit (valid & tag match): ctr increments on taken and saturates at 2'b11; decrements on not-taken and saturates at 2'b00. Target is overwritten with upd_target when taken.
  - Miss and taken: allocate the entry (replacing any victim) with valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss and not-taken: no state change.
- upd_valid=0: no state change; upd_* ignored.
- Same index read and written in one cycle: lookup returns the pre-update (old) value; there is no bypass.
- Aliasing: different PCs sharing an index with different tags never hit each other's entry; allocation evicts.
- Reset asserted mid-update: the reset wins and the update is discarded.

Optional Feature:
- Macro: BRANCH_PREDICTOR_PERF_EN.
- When defined, adds three 32-bit outputs:
  - perf_branches: count of cycles with upd_valid=1.
  - perf_mispredicts: count of cycles with mispredict=1.
  - perf_btb_hits: count of cycles where upd_valid=1 and the upd_pc lookup hits.
- All three counters clear on reset and wrap at 2^32.
- When not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package bp_pkg:
  - counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - CTR_RESET=WNT, CTR_ALLOC=WT.
  - function sat_update(ctr, taken).
- One sub-module is natural: bp_btb_array, holding the storage arrays. It has one combinational read port, one write port and async reset.
- Mispredict and redirect logic stays in the top module.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0. Update 0x100 not-taken -> still miss, no allocation.
- Update pc=0x100 taken, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80.
- Counter saturation on pc=0x100:
  - 3 further taken updates -> ctr=ST.
  - 1 not-taken -> still predicts taken.
  - 2nd not-taken -> pred_taken=0.
  - Not-taken with pred_taken=1 -> mispredict=1, redirect_pc=0x104.
- Target change: taken at 0x100 with upd_target=0xC0, upd_pred_target=0x80, both predicted taken -> mispredict=1, redirect_pc=0xC0. Subsequent lookup of 0x100 -> 0xC0.
- Alias (ENTRIES=16): allocate 0x100, then taken at 0x140 -> 0x140 hits and 0x100 misses. Same-cycle lookup and update of 0x140 returns the old entry.
- Assert reset asynchronously mid-cycle with upd_valid=1 -> all outputs 0 immediately, tables cleared. With BRANCH_PREDICTOR_PERF_EN, all perf counters read 0.
